sonic_v1_15_eth_10g_pa_pg_after_timing_adapter: RTL
===================================================

// Module: sonic_v1_15_eth_10g_pa_pg_after_timing_adapter
// PURPOSE
//  Avalon-ST timing adapter on the output side of the 10G pause generator (pa_pg).
//  Upstream is a readyLatency=0 source (in_valid/in_ready/in_data); downstream is a sink with
//  readyLatency=READY_LATENCY. A small FIFO absorbs data in flight while out_ready is delayed.
//  No combinational path from out_ready to in_ready or out_valid.
// PARAMETERS
//  DATA_W        2  payload width (pause request/quanta select)
//  READY_LATENCY 1  downstream ready latency, legal 1..4
//  DEPTH         4  FIFO entries, power of 2, DEPTH >= READY_LATENCY+1 (elaboration error otherwise)
// PORTS
//  clk        in   1       single clock
//  reset_n    in   1       asynchronous active-low reset
//  in_data    in   DATA_W  upstream payload
//  in_valid   in   1       upstream valid
//  in_ready   out  1       adapter can accept this cycle (readyLatency 0)
//  out_data   out  DATA_W  FIFO head payload
//  out_valid  out  1       transfer this cycle
//  out_ready  in   1       downstream ready, honoured READY_LATENCY cycles later
//  stall_cnt  out  16      only with SONIC_PA_PG_TA_STALL_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): count=0, wr/rd pointers=0, ready pipe=0, out_valid=0,
//   out_data=0, in_ready=0; in_ready rises on the first clk edge after reset_n deasserts.
//  Ready pipe: rdy_pipe[0]<=out_ready; rdy_pipe[i]<=rdy_pipe[i-1]; rdy_q=rdy_pipe[READY_LATENCY-1].
//  out_valid = rdy_q && (count!=0); out_data = mem[rd_ptr] (0 when count==0).
//  pop  = out_valid  (sink must accept; no second handshake on the out side).
//  push = in_valid && in_ready; in_ready = en_q && (count!=DEPTH), from registers only.
//  count(next) = count + push - pop; push+pop same cycle -> count unchanged, both pointers advance.
//  Full: in_ready=0; a pop in the same cycle does not reopen in_ready until next cycle.
//  Empty: out_valid=0 even if rdy_q=1 (ready slot wasted, no error).
//  Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//  Latency: a word pushed at edge N is visible as out_valid at cycle N+1 at the earliest,
//   only if rdy_q is high then; ordering strictly FIFO; no data loss or duplication.
//  Throughput: 1 word/cycle sustained when out_ready held high and DEPTH >= READY_LATENCY+1.
//  Downstream dropping out_ready: up to READY_LATENCY further pops may still occur (per protocol);
//   FIFO fills and backpressures upstream.
//  Mid-operation reset: FIFO contents discarded, all outputs return to reset values immediately.
// CONFIGURATION
//  `SONIC_PA_PG_TA_STALL_CNT_EN defined: stall_cnt is a 16-bit saturating counter, reset 0,
//   +1 each cycle with in_valid && !in_ready, holds at 16'hFFFF. Cleared only by reset_n.
//  Not defined: stall_cnt driven constant 16'h0000, no counter logic synthesised.
// TESTING
//  1 Reset: reset_n=0 with in_valid=1 -> in_ready=0, out_valid=0; after release in_ready=1 next edge.
//  2 Stream RL=1, out_ready=1 always, push 0,1,2,3,0,1.. each cycle -> same sequence on out,
//    one word/cycle, first out_valid 1 cycle after first push, count never exceeds 2.
//  3 Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly DEPTH(4) words accepted,
//    in_ready=0 after 4th; out_ready=1 again -> out_valid resumes RL cycles later, order kept.
//  4 RL=3: toggle out_ready 1,0,1,0 -> out_valid only in cycles where out_ready was 1 three
//    cycles earlier and FIFO non-empty; no word lost; scoreboard matches.
//  5 Simultaneous push/pop at count=DEPTH-1 -> count stays DEPTH-1, pointers wrap 3->0 cleanly.
//  6 STALL_CNT_EN: hold full with in_valid=1 for 20 cycles -> stall_cnt=20; force 70000 stall
//    cycles -> stall_cnt=16'hFFFF; mid-stream reset_n pulse -> FIFO empty, stall_cnt=0.

Source files
------------

// File: rtl/sonic_v1_15_eth_10g_pa_pg_after_timing_adapter.sv
// Avalon-ST timing adapter behind the 10G pause generator: readyLatency 0 in, READY_LATENCY out.
// Optional stall counter enabled by `SONIC_PA_PG_TA_STALL_CNT_EN.
module sonic_v1_15_eth_10g_pa_pg_after_timing_adapter #(
  parameter int unsigned DATA_W        = 2,
  parameter int unsigned READY_LATENCY = 1,
  parameter int unsigned DEPTH         = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned RL    = READY_LATENCY;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  generate
    if (RL < 1 || RL > 4) begin : g_bad_rl
      $error("READY_LATENCY must be 1..4");
    end
    if (DEPTH < RL + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least READY_LATENCY+1");
    end
  endgenerate

  logic [RL-1:0]     rdy_pipe;
  logic              rdy_q;
  logic              en_q;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;

  // Handshake decode uses registered state only; out_ready never reaches an output combinationally.
  assign rdy_q     = rdy_pipe[RL-1];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = en_q && !full;
  assign out_valid = rdy_q && !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_pipe <= '0;
      en_q     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      rdy_pipe[0] <= out_ready;
      for (int unsigned i = 1; i < RL; i++) begin
        rdy_pipe[i] <= rdy_pipe[i-1];
      end
      en_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef SONIC_PA_PG_TA_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 16'h0000;
    end else if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
